// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch front end.
//   IMEM_AW          : instruction memory word-address width
//   INST_W           : instruction width
//   PC_W             : program counter width
//   DEPTH_DEFAULT    : default instruction queue depth
//   RESET_PC_DEFAULT : default fetch PC after reset
//   fetch_entry_t    : one queue entry {instruction, address + 4}
package if_pkg;
   localparam int IMEM_AW = 8;
   localparam int INST_W = 32;
   localparam int PC_W = 32;
   localparam int DEPTH_DEFAULT = 4;
   localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [PC_W-1:0]   pcplus4;
   } fetch_entry_t;
endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO holding fetched instructions.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : drop all entries; wins over push and pop
//   push       : write push_data (ignored when full)
//   pop        : remove the head (ignored when empty)
//   head_data  : current head entry (combinational read)
//   full/empty : occupancy flags
//   count      : number of stored entries
module fifo_sync #(
   parameter int WIDTH = 64,
   parameter int DEPTH = if_pkg::DEPTH_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head_data = mem[rd_ptr_reg];

   // Storage has no reset; stale contents are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (push_ok && !flush && !rst) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC, credit-based request issue, one outstanding
// memory response, and an instruction queue toward IF/ID.
//   clk, rst          : clock, synchronous active-high reset
//   redirect          : flush queue and restart fetch at redirect_pc
//   redirect_pc       : new fetch PC (low two bits ignored)
//   imem_req/addr     : memory read request, word address pc[9:2]
//   imem_rdata        : read data, valid one cycle after imem_req
//   out_valid/ready   : handshake toward IF/ID
//   out_inst          : head instruction (0 when queue empty)
//   out_pcplus4       : head instruction address + 4 (0 when queue empty)
module if_fetch
   import if_pkg::*;
#(
   parameter int              DEPTH    = DEPTH_DEFAULT,
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [INST_W-1:0]  imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INST_W-1:0]  out_inst,
   output logic [PC_W-1:0]    out_pcplus4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [PC_W-1:0] pc_reg;
   logic [PC_W-1:0] req_pcplus4_reg;
   logic            inflight_reg;
   logic [CW-1:0]   fifo_count;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW:0]     occupancy;
   logic            issue;
   logic            push;
   logic            pop;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;

   // Queued entries plus the response still in flight must fit in the
   // queue, so every response has a guaranteed slot. No pop lookahead.
   assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_reg};
   assign issue     = !rst && !redirect && !fifo_full
                      && (occupancy < (CW+1)'(DEPTH));
   assign push      = inflight_reg && !redirect;
   assign pop       = out_valid && out_ready;

   assign imem_req  = issue;
   assign imem_addr = pc_reg[IMEM_AW+1:2];

   assign push_entry.inst    = imem_rdata;
   assign push_entry.pcplus4 = req_pcplus4_reg;

   assign out_valid   = !fifo_empty;
   assign out_inst    = fifo_empty ? '0 : head_entry.inst;
   assign out_pcplus4 = fifo_empty ? '0 : head_entry.pcplus4;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg          <= RESET_PC;
         req_pcplus4_reg <= '0;
         inflight_reg    <= 1'b0;
      end else if (redirect) begin
         pc_reg       <= {redirect_pc[PC_W-1:2], 2'b00};
         inflight_reg <= 1'b0;
      end else begin
         inflight_reg <= issue;
         if (issue) begin
            pc_reg          <= pc_reg + 32'd4;
            req_pcplus4_reg <= pc_reg + 32'd4;
         end
      end
   end

   fifo_sync #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );
endmodule
